// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state/grant encodings and arbitration pick function
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_INST = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } arb_grant_t;

  // Choose the next owner among eligible requesters; prefer_inst breaks ties.
  function automatic arb_state_t arb_pick(input logic inst_cand,
                                          input logic data_cand,
                                          input logic prefer_inst);
    if (inst_cand && data_cand) return prefer_inst ? ARB_INST : ARB_DATA;
    else if (data_cand)         return ARB_DATA;
    else if (inst_cand)         return ARB_INST;
    else                        return ARB_IDLE;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester, RAM bus and stall signals of the RAM arbiter
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_ready;

  logic              data_req;
  logic [3:0]        data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ready;

  logic              bus_en;
  logic [3:0]        bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  logic              stall_req;

  // Arbiter side.
  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
           bus_rdata, bus_ready,
    output inst_rdata, inst_ready, data_rdata, data_ready,
           bus_en, bus_we, bus_addr, bus_wdata, stall_req
  );

  // Pipeline/RAM environment side.
  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
           bus_rdata, bus_ready,
    input  inst_rdata, inst_ready, data_rdata, data_ready,
           bus_en, bus_we, bus_addr, bus_wdata, stall_req
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - IF/MEM arbiter onto one RAM port; RAM_ARB_RR_EN selects round-robin
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave io
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              w_busy;
  logic              w_done;
  logic              w_issue;
  logic              w_inst_cand;
  logic              w_data_cand;
  logic              w_prefer_inst;
  logic [ADDR_W-1:0] w_inst_addr;

  logic              r_bus_en;
  logic [3:0]        r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_inst_ready;
  logic              r_data_ready;

  assign w_busy      = (r_state != ARB_IDLE);
  assign w_done      = w_busy & io.bus_ready;
  assign w_inst_addr = io.inst_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};

`ifdef RAM_ARB_RR_EN
  arb_grant_t r_last;

  assign w_prefer_inst = (r_last == GNT_DATA);

  // Remember who won the most recent grant so a tie goes to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last <= GNT_INST;
    else if (w_issue) r_last <= (w_next_state == ARB_DATA) ? GNT_DATA : GNT_INST;
  end
`else
  assign w_prefer_inst = 1'b0;
`endif

  // Arbitration: decide in IDLE or at a completion edge, masking the finishing requester.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_inst_cand  = io.inst_req & (r_state != ARB_INST);
    w_data_cand  = io.data_req & (r_state != ARB_DATA);
    if (!w_busy || w_done) begin
      w_next_state = arb_pick(w_inst_cand, w_data_cand, w_prefer_inst);
      w_issue      = (w_next_state != ARB_IDLE);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_next_state;
  end

  // Bus command registers, read-data capture and one-cycle ready pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_en     <= 1'b0;
      r_bus_we     <= 4'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_inst_ready <= 1'b0;
      r_data_ready <= 1'b0;
      if (w_done) begin
        if (r_state == ARB_INST) begin
          r_inst_rdata <= io.bus_rdata;
          r_inst_ready <= 1'b1;
        end else begin
          r_data_rdata <= io.bus_rdata;
          r_data_ready <= 1'b1;
        end
      end
      if (w_issue) begin
        r_bus_en <= 1'b1;
        if (w_next_state == ARB_INST) begin
          r_bus_we    <= 4'b0;
          r_bus_addr  <= w_inst_addr;
          r_bus_wdata <= '0;
        end else begin
          r_bus_we    <= io.data_we;
          r_bus_addr  <= io.data_addr;
          r_bus_wdata <= io.data_wdata;
        end
      end else if (w_done) begin
        r_bus_en <= 1'b0;
      end
    end
  end

  assign io.bus_en     = r_bus_en;
  assign io.bus_we     = r_bus_we;
  assign io.bus_addr   = r_bus_addr;
  assign io.bus_wdata  = r_bus_wdata;
  assign io.inst_rdata = r_inst_rdata;
  assign io.inst_ready = r_inst_ready;
  assign io.data_rdata = r_data_rdata;
  assign io.data_ready = r_data_ready;
  assign io.stall_req  = (io.inst_req & ~r_inst_ready) | (io.data_req & ~r_data_ready);

endmodule
